// File: rtl/line_refill_ctrl_if.sv
// Bundle of the request-side and bus-side signals of the cache line refill
// controller. The slave modport is the controller's view and the master
// modport is the view of the environment that drives it (cache + bus block).
interface line_refill_ctrl_if #(
  parameter int LINE_WORDS = 8
);
  // Cache side: miss request and victim line
  logic                      req_valid;
  logic [31:0]               req_addr;
  logic                      req_wb;
  logic [31:0]               wb_addr;
  logic [32*LINE_WORDS-1:0]  wb_line;

  // Cache side: status and refilled line
  logic                      busy;
  logic                      fill_done;
  logic [32*LINE_WORDS-1:0]  fill_line;
  logic [31:0]               fill_addr;
  logic                      crit_valid;
  logic [31:0]               crit_data;

  // Bus block side
  logic                      axi_ar_en;
  logic                      axi_aw_en;
  logic [31:0]               cpu_rd_addr;
  logic [31:0]               cpu_wr_addr;
  logic [31:0]               cpu_wr_data;
  logic [7:0]                ar_burst_len;
  logic [7:0]                aw_burst_len;
  logic [1:0]                ar_burst_step;
  logic [1:0]                aw_burst_step;
  logic [31:0]               cpu_rd_data;
  logic                      bus_rd_data_ready;
  logic                      bus_wr_data_ready;
  logic                      bus_wr_data_finish;

  modport slave (
    input  req_valid, req_addr, req_wb, wb_addr, wb_line,
    input  cpu_rd_data, bus_rd_data_ready, bus_wr_data_ready, bus_wr_data_finish,
    output busy, fill_done, fill_line, fill_addr, crit_valid, crit_data,
    output axi_ar_en, axi_aw_en, cpu_rd_addr, cpu_wr_addr, cpu_wr_data,
    output ar_burst_len, aw_burst_len, ar_burst_step, aw_burst_step
  );

  modport master (
    output req_valid, req_addr, req_wb, wb_addr, wb_line,
    output cpu_rd_data, bus_rd_data_ready, bus_wr_data_ready, bus_wr_data_finish,
    input  busy, fill_done, fill_line, fill_addr, crit_valid, crit_data,
    input  axi_ar_en, axi_aw_en, cpu_rd_addr, cpu_wr_addr, cpu_wr_data,
    input  ar_burst_len, aw_burst_len, ar_burst_step, aw_burst_step
  );
endinterface

// File: rtl/line_refill_ctrl.sv
// Cache line refill controller: on a miss, optionally writes back the dirty
// victim line as one burst, waits two idle cycles so the edge-triggered bus
// block can return to idle, then reads the new line as one burst and presents
// it with a one-cycle fill_done pulse.
// Optional feature macro CRIT_WORD_EN: pulses crit_valid/crit_data the cycle
// after the requested (critical) word arrives on the read burst.
module line_refill_ctrl #(
  parameter int LINE_WORDS = 8
) (
  input  logic              clk,
  input  logic              reset,
  line_refill_ctrl_if.slave bus
);
  localparam int              LW_BITS    = $clog2(LINE_WORDS);
  localparam logic [LW_BITS:0] LW_CNT    = (LW_BITS+1)'(LINE_WORDS);
  localparam logic [LW_BITS:0] CNT_ONE   = (LW_BITS+1)'(1);
  localparam logic [31:0]     ALIGN_MASK = ~(32'(LINE_WORDS) * 32'd4 - 32'd1);

  typedef enum logic [2:0] {IDLE, WB, WB_GAP, RD, DONE} state_t;
  typedef logic [LINE_WORDS-1:0][31:0] line_t;

  state_t           state_q, state_d;
  logic [31:0]      line_addr_q, victim_addr_q, fill_addr_q;
  line_t            victim_q, rd_buf_q, rd_buf_d, fill_line_q;
  logic [LW_BITS:0] wr_idx_q, rd_idx_q;
  logic             gap_cnt_q;
  logic             after_done_q;
  logic             accept, rd_beat, wr_beat, last_beat;

  // A request is taken only in IDLE and never in the cycle right after DONE,
  // which keeps axi_ar_en low for at least two cycles between bursts.
  assign accept    = (state_q == IDLE) && bus.req_valid && !after_done_q;
  assign rd_beat   = (state_q == RD) && bus.bus_rd_data_ready && (rd_idx_q < LW_CNT);
  assign wr_beat   = (state_q == WB) && bus.bus_wr_data_ready && (wr_idx_q < LW_CNT);
  assign last_beat = rd_beat && (rd_idx_q == LW_CNT - CNT_ONE);

  assign bus.ar_burst_len  = 8'(LINE_WORDS - 1);
  assign bus.aw_burst_len  = 8'(LINE_WORDS - 1);
  assign bus.ar_burst_step = 2'd1;
  assign bus.aw_burst_step = 2'd1;
  assign bus.cpu_rd_addr   = line_addr_q;
  assign bus.cpu_wr_addr   = victim_addr_q;
  assign bus.cpu_wr_data   = (wr_idx_q < LW_CNT) ? victim_q[wr_idx_q[LW_BITS-1:0]] : 32'd0;
  assign bus.fill_line     = fill_line_q;
  assign bus.fill_addr     = fill_addr_q;

  // Next-state and per-state bus/status outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    state_d       = state_q;
    bus.busy      = (state_q != IDLE);
    bus.fill_done = 1'b0;
    bus.axi_ar_en = 1'b0;
    bus.axi_aw_en = 1'b0;
    unique case (state_q)
      IDLE:    if (accept) state_d = bus.req_wb ? WB : RD;
      WB: begin
        bus.axi_aw_en = 1'b1;
        if (bus.bus_wr_data_finish) state_d = WB_GAP;
      end
      WB_GAP:  if (gap_cnt_q) state_d = RD;
      RD: begin
        bus.axi_ar_en = 1'b1;
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        bus.fill_done = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read beats collect in a staging buffer so fill_line only changes at DONE.
  always_comb begin
    rd_buf_d = rd_buf_q;
    if (rd_beat) rd_buf_d[rd_idx_q[LW_BITS-1:0]] = bus.cpu_rd_data;
  end

  // State, request latches, beat counters and the published line.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q       <= IDLE;
      after_done_q  <= 1'b0;
      gap_cnt_q     <= 1'b0;
      line_addr_q   <= '0;
      victim_addr_q <= '0;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      // NOTE: the line buffers are reset as well because fill_line and
      // cpu_wr_data are visible outputs that must read zero after reset.
      victim_q      <= '0;
      rd_buf_q      <= '0;
      fill_line_q   <= '0;
      fill_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      after_done_q <= (state_q == DONE);
      gap_cnt_q    <= (state_q == WB_GAP) ? ~gap_cnt_q : 1'b0;
      rd_buf_q     <= rd_buf_d;
      if (accept) begin
        line_addr_q   <= bus.req_addr & ALIGN_MASK;
        victim_addr_q <= bus.wb_addr & ALIGN_MASK;
        victim_q      <= bus.wb_line;
        wr_idx_q      <= '0;
        rd_idx_q      <= '0;
      end
      if (wr_beat) wr_idx_q <= wr_idx_q + CNT_ONE;
      if (rd_beat) rd_idx_q <= rd_idx_q + CNT_ONE;
      if (last_beat) begin
        fill_line_q <= rd_buf_d;
        fill_addr_q <= line_addr_q;
      end
    end
  end

`ifdef CRIT_WORD_EN
  logic [LW_BITS-1:0] word_off_q;
  logic               crit_valid_q;
  logic [31:0]        crit_data_q;
  logic               crit_hit;

  assign crit_hit       = rd_beat && (rd_idx_q[LW_BITS-1:0] == word_off_q);
  assign bus.crit_valid = crit_valid_q;
  assign bus.crit_data  = crit_data_q;

  // Capture the critical word as it passes on the read burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_off_q   <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      if (accept) word_off_q <= bus.req_addr[LW_BITS+1:2];
      crit_valid_q <= crit_hit;
      if (crit_hit) crit_data_q <= bus.cpu_rd_data;
    end
  end
`else
  assign bus.crit_valid = 1'b0;
  assign bus.crit_data  = 32'd0;
`endif

endmodule

// File: tb/tb_line_refill_ctrl.sv
// Directed self-checking bench for line_refill_ctrl (LINE_WORDS = 8).
// Inputs change on the falling edge; outputs are read on the falling edge.
module tb_line_refill_ctrl;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  line_refill_ctrl_if #(.LINE_WORDS(LW)) bus ();
  line_refill_ctrl #(.LINE_WORDS(LW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;

  // Edge/pulse monitor, sampled shortly after each rising edge.
  int   cyc = 0, ar_rises = 0, ar_rise_cyc = 0, ar_fall_cyc = 0, aw_fall_cyc = 0, done_cycles = 0;
  logic ar_prev = 1'b0, aw_prev = 1'b0;
  always @(posedge clk) begin
    #2;
    cyc++;
    if (bus.axi_ar_en === 1'b1 && ar_prev === 1'b0) begin ar_rises++; ar_rise_cyc = cyc; end
    if (bus.axi_ar_en === 1'b0 && ar_prev === 1'b1) ar_fall_cyc = cyc;
    if (bus.axi_aw_en === 1'b0 && aw_prev === 1'b1) aw_fall_cyc = cyc;
    if (bus.fill_done === 1'b1) done_cycles++;
    ar_prev = bus.axi_ar_en;
    aw_prev = bus.axi_aw_en;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [32*LW-1:0] make_line(input logic [31:0] base);
    logic [32*LW-1:0] l;
    for (int i = 0; i < LW; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Presents a request for one cycle; returns on the edge after acceptance.
  task automatic send_req(input logic [31:0] addr, input logic wb,
                          input logic [31:0] waddr, input logic [32*LW-1:0] wline);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_wb    = wb;
    bus.wb_addr   = waddr;
    bus.wb_line   = wline;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Eight back-to-back read beats base..base+7; returns in the DONE cycle.
  task automatic read_burst(input logic [31:0] base);
    for (int i = 0; i < LW; i++) begin
      bus.bus_rd_data_ready = 1'b1;
      bus.cpu_rd_data       = base + 32'(i);
      @(negedge clk);
    end
    bus.bus_rd_data_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.fill_done !== 1'b0) begin miscompares++; $display("FAIL reset_fill_done: got %b want 0", bus.fill_done); end
    vectors++; if ({bus.axi_ar_en, bus.axi_aw_en} !== 2'b00) begin miscompares++; $display("FAIL reset_en: got ar/aw %b%b want 00", bus.axi_ar_en, bus.axi_aw_en); end
    vectors++; if (bus.crit_valid !== 1'b0 || bus.crit_data !== 32'd0) begin miscompares++; $display("FAIL reset_crit: got %b/%h want 0/0", bus.crit_valid, bus.crit_data); end
    vectors++; if (bus.fill_line !== '0 || bus.fill_addr !== 32'd0) begin miscompares++; $display("FAIL reset_fill: got addr %h line %h want zeros", bus.fill_addr, bus.fill_line); end
    vectors++; if (bus.cpu_rd_addr !== 32'd0 || bus.cpu_wr_addr !== 32'd0 || bus.cpu_wr_data !== 32'd0) begin miscompares++; $display("FAIL reset_bus_addr: got rd %h wr %h data %h want 0", bus.cpu_rd_addr, bus.cpu_wr_addr, bus.cpu_wr_data); end
    vectors++; if (bus.ar_burst_len !== 8'd7 || bus.aw_burst_len !== 8'd7 || bus.ar_burst_step !== 2'd1 || bus.aw_burst_step !== 2'd1) begin
      miscompares++; $display("FAIL burst_consts: got len %0d/%0d step %0d/%0d want 7/7 1/1", bus.ar_burst_len, bus.aw_burst_len, bus.ar_burst_step, bus.aw_burst_step); end
  endtask

  task automatic test_clean_miss();
    int rises0, done0;
    rises0 = ar_rises;
    done0  = done_cycles;
    send_req(32'h1000_0014, 1'b0, 32'h0, '0);
    vectors++; if (bus.busy !== 1'b1 || bus.axi_ar_en !== 1'b1 || bus.axi_aw_en !== 1'b0) begin miscompares++; $display("FAIL clean_start: got busy %b ar %b aw %b want 1 1 0", bus.busy, bus.axi_ar_en, bus.axi_aw_en); end
    vectors++; if (bus.cpu_rd_addr !== 32'h1000_0000) begin miscompares++; $display("FAIL clean_rd_addr: got %h want 10000000", bus.cpu_rd_addr); end
    read_burst(32'hA0);
    vectors++; if (bus.fill_done !== 1'b1 || bus.axi_ar_en !== 1'b0) begin miscompares++; $display("FAIL clean_done: got fill_done %b ar %b want 1 0", bus.fill_done, bus.axi_ar_en); end
    vectors++; if (bus.fill_line[32*5 +: 32] !== 32'hA5) begin miscompares++; $display("FAIL clean_word5: got %h want a5", bus.fill_line[32*5 +: 32]); end
    vectors++; if (bus.fill_line !== make_line(32'hA0) || bus.fill_addr !== 32'h1000_0000) begin miscompares++; $display("FAIL clean_line: got %h @%h want %h @10000000", bus.fill_line, bus.fill_addr, make_line(32'hA0)); end
    @(negedge clk);
    vectors++; if (bus.fill_done !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL clean_idle: got fill_done %b busy %b want 0 0", bus.fill_done, bus.busy); end
    vectors++; if (ar_rises - rises0 != 1 || done_cycles - done0 != 1) begin miscompares++; $display("FAIL clean_counts: got ar rises %0d done cycles %0d want 1 1", ar_rises - rises0, done_cycles - done0); end
    vectors++; if (bus.fill_line !== make_line(32'hA0)) begin miscompares++; $display("FAIL clean_hold: got %h want %h", bus.fill_line, make_line(32'hA0)); end
  endtask

  task automatic test_dirty_miss();
    repeat (2) @(negedge clk);
    send_req(32'h2000_0040, 1'b1, 32'h2000_0020, make_line(32'hB0));
    vectors++; if (bus.axi_aw_en !== 1'b1 || bus.axi_ar_en !== 1'b0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL dirty_wb_state: got aw %b ar %b busy %b want 1 0 1", bus.axi_aw_en, bus.axi_ar_en, bus.busy); end
    vectors++; if (bus.cpu_wr_addr !== 32'h2000_0020) begin miscompares++; $display("FAIL dirty_wr_addr: got %h want 20000020", bus.cpu_wr_addr); end
    for (int i = 0; i < LW; i++) begin
      vectors++; if (bus.cpu_wr_data !== 32'hB0 + 32'(i)) begin miscompares++; $display("FAIL dirty_wr_data[%0d]: got %h want %h", i, bus.cpu_wr_data, 32'hB0 + 32'(i)); end
      bus.bus_wr_data_ready = 1'b1;
      @(negedge clk);
    end
    bus.bus_wr_data_ready  = 1'b0;
    bus.bus_wr_data_finish = 1'b1;
    @(negedge clk);
    bus.bus_wr_data_finish = 1'b0;
    vectors++; if (bus.axi_aw_en !== 1'b0 || bus.axi_ar_en !== 1'b0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL dirty_gap1: got aw %b ar %b busy %b want 0 0 1", bus.axi_aw_en, bus.axi_ar_en, bus.busy); end
    @(negedge clk);
    vectors++; if (bus.axi_ar_en !== 1'b0) begin miscompares++; $display("FAIL dirty_gap2: got ar %b want 0", bus.axi_ar_en); end
    @(negedge clk);
    vectors++; if (bus.axi_ar_en !== 1'b1 || ar_rise_cyc - aw_fall_cyc != 2) begin miscompares++; $display("FAIL dirty_gap_len: got ar %b gap %0d want 1 2", bus.axi_ar_en, ar_rise_cyc - aw_fall_cyc); end
    vectors++; if (bus.cpu_rd_addr !== 32'h2000_0040) begin miscompares++; $display("FAIL dirty_rd_addr: got %h want 20000040", bus.cpu_rd_addr); end
    read_burst(32'hC0);
    vectors++; if (bus.fill_done !== 1'b1 || bus.fill_line !== make_line(32'hC0) || bus.fill_addr !== 32'h2000_0040) begin
      miscompares++; $display("FAIL dirty_fill: got done %b line %h @%h want 1 %h @20000040", bus.fill_done, bus.fill_line, bus.fill_addr, make_line(32'hC0)); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int done0, fall1;
    bit seen;
    repeat (2) @(negedge clk);
    done0 = done_cycles;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h3000_0044;
    bus.req_wb    = 1'b0;
    @(negedge clk);
    read_burst(32'h10);
    fall1 = ar_fall_cyc;
    seen  = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.axi_ar_en === 1'b1) seen = 1'b1;
    end
    bus.req_valid = 1'b0;
    vectors++; if (!seen) begin miscompares++; $display("FAIL b2b_second_rise: got no axi_ar_en within 10 cycles want rise"); end
    vectors++; if (ar_rise_cyc - fall1 < 2) begin miscompares++; $display("FAIL b2b_low_gap: got %0d cycles low want >= 2", ar_rise_cyc - fall1); end
    read_burst(32'h20);
    vectors++; if (bus.fill_line !== make_line(32'h20) || bus.fill_addr !== 32'h3000_0040) begin miscompares++; $display("FAIL b2b_fill: got %h @%h want %h @30000040", bus.fill_line, bus.fill_addr, make_line(32'h20)); end
    @(negedge clk);
    vectors++; if (done_cycles - done0 != 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 2", done_cycles - done0); end
  endtask

  task automatic test_reset_midburst();
    int done0;
    repeat (2) @(negedge clk);
    done0 = done_cycles;
    send_req(32'h4000_0008, 1'b0, 32'h0, '0);
    for (int i = 0; i < 3; i++) begin
      bus.bus_rd_data_ready = 1'b1;
      bus.cpu_rd_data       = 32'h50 + 32'(i);
      @(negedge clk);
    end
    bus.cpu_rd_data = 32'h53;
    reset           = 1'b1;
    @(negedge clk);
    reset                 = 1'b0;
    bus.bus_rd_data_ready = 1'b0;
    vectors++; if ({bus.busy, bus.fill_done, bus.axi_ar_en, bus.axi_aw_en, bus.crit_valid} !== 5'b0) begin
      miscompares++; $display("FAIL midreset_flags: got busy/done/ar/aw/crit %b want 00000", {bus.busy, bus.fill_done, bus.axi_ar_en, bus.axi_aw_en, bus.crit_valid}); end
    vectors++; if (bus.fill_line !== '0 || bus.fill_addr !== 32'd0 || bus.cpu_rd_addr !== 32'd0) begin miscompares++; $display("FAIL midreset_regs: got line %h addr %h rd_addr %h want zeros", bus.fill_line, bus.fill_addr, bus.cpu_rd_addr); end
    repeat (3) @(negedge clk);
    vectors++; if (done_cycles != done0) begin miscompares++; $display("FAIL midreset_no_done: got %0d pulses want 0", done_cycles - done0); end
    send_req(32'h5000_0004, 1'b0, 32'h0, '0);
    read_burst(32'h60);
    vectors++; if (bus.fill_done !== 1'b1 || bus.fill_line !== make_line(32'h60) || bus.fill_addr !== 32'h5000_0000) begin
      miscompares++; $display("FAIL midreset_recover: got done %b line %h @%h want 1 %h @50000000", bus.fill_done, bus.fill_line, bus.fill_addr, make_line(32'h60)); end
    @(negedge clk);
  endtask

  task automatic test_crit_word();
    repeat (2) @(negedge clk);
    send_req(32'h6000_0018, 1'b0, 32'h0, '0);
    for (int i = 0; i < LW; i++) begin
      bus.bus_rd_data_ready = 1'b1;
      bus.cpu_rd_data       = 32'hD0 + 32'(i);
      @(negedge clk);
      if (i == 6) begin
`ifdef CRIT_WORD_EN
        vectors++; if (bus.crit_valid !== 1'b1 || bus.crit_data !== 32'hD6) begin miscompares++; $display("FAIL crit_pulse: got %b/%h want 1/d6", bus.crit_valid, bus.crit_data); end
`else
        vectors++; if (bus.crit_valid !== 1'b0 || bus.crit_data !== 32'd0) begin miscompares++; $display("FAIL crit_tied: got %b/%h want 0/0", bus.crit_valid, bus.crit_data); end
`endif
      end
    end
    bus.bus_rd_data_ready = 1'b0;
    vectors++; if (bus.crit_valid !== 1'b0 || bus.fill_done !== 1'b1) begin miscompares++; $display("FAIL crit_one_cycle: got crit %b done %b want 0 1", bus.crit_valid, bus.fill_done); end
    @(negedge clk);
  endtask

  task automatic test_stray_beats();
    int done0;
    repeat (2) @(negedge clk);
    done0 = done_cycles;
    bus.bus_rd_data_ready  = 1'b1;
    bus.cpu_rd_data        = 32'hDEAD_BEEF;
    bus.bus_wr_data_ready  = 1'b1;
    bus.bus_wr_data_finish = 1'b1;
    @(negedge clk);
    bus.bus_rd_data_ready  = 1'b0;
    bus.bus_wr_data_ready  = 1'b0;
    bus.bus_wr_data_finish = 1'b0;
    @(negedge clk);
    vectors++; if (bus.fill_line !== make_line(32'hD0) || bus.busy !== 1'b0) begin miscompares++; $display("FAIL stray_idle: got line %h busy %b want %h 0", bus.fill_line, bus.busy, make_line(32'hD0)); end
    send_req(32'h7000_0000, 1'b0, 32'h0, '0);
    read_burst(32'hE0);
    bus.bus_rd_data_ready = 1'b1;
    bus.cpu_rd_data       = 32'h0000_0BAD;
    @(negedge clk);
    bus.bus_rd_data_ready = 1'b0;
    vectors++; if (bus.fill_done !== 1'b0 || bus.fill_line !== make_line(32'hE0)) begin miscompares++; $display("FAIL stray_ninth: got done %b line %h want 0 %h", bus.fill_done, bus.fill_line, make_line(32'hE0)); end
    repeat (2) @(negedge clk);
    vectors++; if (done_cycles - done0 != 1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL stray_done_count: got %0d busy %b want 1 0", done_cycles - done0, bus.busy); end
  endtask

  initial begin
    reset                  = 1'b0;
    bus.req_valid          = 1'b0;
    bus.req_addr           = '0;
    bus.req_wb             = 1'b0;
    bus.wb_addr            = '0;
    bus.wb_line            = '0;
    bus.cpu_rd_data        = '0;
    bus.bus_rd_data_ready  = 1'b0;
    bus.bus_wr_data_ready  = 1'b0;
    bus.bus_wr_data_finish = 1'b0;

    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_back_to_back();
    test_reset_midburst();
    test_crit_word();
    test_stray_beats();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
